aes_if_responder: RTL

// Responder end of the scan-chain AES interface (SCAN_CHAIN/ENABLE in, TRIGGER_EXT/CIPHERTEXT out).

---
 rtl/aes_if_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/aes_if_responder.sv
// aes_if_responder: scan-chain AES responder; unpacks the scan word, drives an iterative
// engine over a load/busy handshake and marks engine start and result with two trigger pulses.
module aes_if_responder #(
    parameter int TRIG_LEN = 4,
    parameter int TIMEOUT  = 1024,
    parameter int KEY_SIZE = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [386:0] SCAN_CHAIN,
    input  logic         ENABLE,
    output logic         TRIGGER_EXT,
    output logic [386:0] CIPHERTEXT,
    output logic [127:0] CT_OUT,
    output logic         TIMEOUT_O,
    output logic         ENG_LOAD,
    output logic [127:0] ENG_DATA,
    output logic [255:0] ENG_KEY,
    output logic [1:0]   ENG_SIZE,
    output logic         ENG_DEC,
    input  logic         ENG_BUSY,
    input  logic [127:0] ENG_RESULT
);
    localparam int TW = $clog2(TRIG_LEN + 1);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, FINISH, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [255:0]  key_q, key_d;
    logic [127:0]  pt_q, pt_d, ct_q, ct_d, ct_out_q, ct_out_d;
    logic [386:0]  cipher_q, cipher_d;
    logic [TW-1:0] trig_cnt_q, trig_cnt_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          trig_q, trig_d, p2_q, p2_d, busy_seen_q, busy_seen_d;
    logic          tmo_q, tmo_d, load_q, load_d;
    logic          trig_end, eng_done;

    assign trig_end = trig_q && (trig_cnt_q == TW'(TRIG_LEN - 1));
    assign eng_done = busy_seen_q && !ENG_BUSY;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        key_d       = key_q;
        pt_d        = pt_q;
        ct_d        = ct_q;
        ct_out_d    = ct_out_q;
        cipher_d    = cipher_q;
        p2_d        = p2_q;
        busy_seen_d = busy_seen_q;
        tmo_d       = tmo_q;
        load_d      = 1'b0;
        tmo_cnt_d   = tmo_cnt_q;
        trig_d      = trig_q && !trig_end;
        trig_cnt_d  = trig_d ? trig_cnt_q + TW'(1) : '0;
        case (state_q)
            IDLE: if (ENABLE) begin
                sel_d      = SCAN_CHAIN[2:0];
                key_d      = SCAN_CHAIN[1] ? SCAN_CHAIN[258:3] : key_q;
                pt_d       = SCAN_CHAIN[2] ? SCAN_CHAIN[386:259] : ct_q;
                tmo_d      = 1'b0;
                load_d     = 1'b1;
                trig_d     = 1'b1;
                trig_cnt_d = '0;
                tmo_cnt_d  = '0;
                state_d    = LOAD;
            end
            LOAD: begin
                busy_seen_d = 1'b0;
                p2_d        = 1'b0;
                tmo_cnt_d   = tmo_cnt_q + CW'(1);
                state_d     = RUN;
            end
            RUN: begin
                tmo_cnt_d   = tmo_cnt_q + CW'(1);
                busy_seen_d = busy_seen_q || ENG_BUSY;
                if (eng_done) begin
                    ct_d    = ENG_RESULT;
                    state_d = FINISH;
                end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
                    ct_d    = '0;
                    tmo_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            // pulse 2 waits for pulse 1 to end plus one low cycle; outputs update on its rising edge
            FINISH: if (!p2_q && !trig_q) begin
                trig_d   = 1'b1;
                p2_d     = 1'b1;
                cipher_d = {sel_q, key_q, ct_q};
                ct_out_d = sel_q[0] ? ct_q : '0;
            end else if (p2_q && trig_end) begin
                state_d = DONE;
            end
            DONE: if (!ENABLE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            key_q       <= '0;
            pt_q        <= '0;
            ct_q        <= '0;
            ct_out_q    <= '0;
            cipher_q    <= '0;
            p2_q        <= 1'b0;
            busy_seen_q <= 1'b0;
            tmo_q       <= 1'b0;
            load_q      <= 1'b0;
            tmo_cnt_q   <= '0;
            trig_q      <= 1'b0;
            trig_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            ct_q        <= ct_d;
            ct_out_q    <= ct_out_d;
            cipher_q    <= cipher_d;
            p2_q        <= p2_d;
            busy_seen_q <= busy_seen_d;
            tmo_q       <= tmo_d;
            load_q      <= load_d;
            tmo_cnt_q   <= tmo_cnt_d;
            trig_q      <= trig_d;
            trig_cnt_q  <= trig_cnt_d;
        end
    end

    assign TRIGGER_EXT = trig_q;
    assign CIPHERTEXT  = cipher_q;
    assign CT_OUT      = ct_out_q;
    assign TIMEOUT_O   = tmo_q;
    assign ENG_LOAD    = load_q;
    assign ENG_DATA    = pt_q;
    assign ENG_KEY     = key_q;
    assign ENG_SIZE    = 2'(KEY_SIZE);
    assign ENG_DEC     = 1'b0;
endmodule
